// File: rtl/inst_cache_pkg.sv
// Shared configuration for the instruction cache: geometry defaults, FSM encoding
// and address helpers.
package inst_cache_pkg;

    localparam int ICACHE_INDEX_BITS = 4;
    localparam int ICACHE_BLOCK_BITS = 2;

    typedef enum logic {
        IC_IDLE   = 1'b0,
        IC_REFILL = 1'b1
    } ic_state_t;

    // Byte address of word 0 of the line containing addr.
    function automatic logic [31:0] line_base(input logic [31:0] addr, input int block_bits);
        logic [31:0] mask;
        mask = 32'hFFFF_FFFF << (block_bits + 2);
        return addr & mask;
    endfunction

endpackage

// File: rtl/icache_line_array.sv
// Valid/tag/data storage for the direct-mapped instruction cache.
// Combinational lookup port, one word-write port and one tag/valid install port.
module icache_line_array
    import inst_cache_pkg::*;
#(
    parameter int INDEX_BITS = ICACHE_INDEX_BITS,
    parameter int BLOCK_BITS = ICACHE_BLOCK_BITS,
    parameter int TAG_BITS   = 32 - ICACHE_INDEX_BITS - ICACHE_BLOCK_BITS - 2
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [INDEX_BITS-1:0] rd_index,
    input  logic [BLOCK_BITS-1:0] rd_offset,
    input  logic [TAG_BITS-1:0]   rd_tag,
    output logic                  rd_hit,
    output logic [31:0]           rd_word,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_index,
    input  logic [BLOCK_BITS-1:0] wr_offset,
    input  logic [31:0]           wr_word,
    input  logic                  set_en,
    input  logic [TAG_BITS-1:0]   set_tag
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int WORDS = 1 << BLOCK_BITS;

    logic [LINES-1:0]    valid;
    logic [TAG_BITS-1:0] tags  [LINES];
    logic [31:0]         words [LINES][WORDS];

    assign rd_hit  = valid[rd_index] && (tags[rd_index] == rd_tag);
    assign rd_word = words[rd_index][rd_offset];

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid <= '0;
        end else if (set_en) begin
            valid[wr_index] <= 1'b1;
            tags[wr_index]  <= set_tag;
        end
    end

    // Data carries no reset: a line is only readable once its valid bit is set.
    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            words[wr_index][wr_offset] <= wr_word;
        end
    end

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache: one fetch at a time, hits answer next
// cycle, misses refill the whole line in word order before answering.
//
//   state     | meaning
//   IC_IDLE   | accepting fetches; hits answered next cycle, a miss starts a refill
//   IC_REFILL | fetching line words 0..N-1 from memory; response dropped if flushed
module inst_cache
    import inst_cache_pkg::*;
#(
    parameter int INDEX_BITS = ICACHE_INDEX_BITS,
    parameter int BLOCK_BITS = ICACHE_BLOCK_BITS
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_handle,
    output logic        inst_ready,
    output logic [31:0] inst_out,
    input  logic        rob_clear,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_done,
    input  logic [31:0] mem_data
);

    localparam int TAG_BITS = 32 - INDEX_BITS - BLOCK_BITS - 2;
    localparam int IDX_LO   = BLOCK_BITS + 2;
    localparam int TAG_LO   = INDEX_BITS + BLOCK_BITS + 2;
    localparam logic [BLOCK_BITS-1:0] LAST_WORD = '1;

    ic_state_t             state, state_next;
    logic [31:0]           req_addr;
    logic [BLOCK_BITS-1:0] word_cnt;
    logic                  drop;

    logic                  hit;
    logic [31:0]           rd_word;
    logic                  word_fire;
    logic                  last_fire;

    // During a refill the lookup port reads the pending request so earlier words can be returned.
    logic [31:0] lookup_addr;
    assign lookup_addr = (state == IC_REFILL) ? req_addr : inst_addr;

    logic [INDEX_BITS-1:0] lookup_index;
    logic [BLOCK_BITS-1:0] lookup_offset;
    logic [TAG_BITS-1:0]   lookup_tag;
    logic [INDEX_BITS-1:0] refill_index;
    logic [BLOCK_BITS-1:0] req_offset;
    logic [TAG_BITS-1:0]   refill_tag;
    logic                  unused_low;

    assign lookup_index  = lookup_addr[TAG_LO-1:IDX_LO];
    assign lookup_offset = lookup_addr[IDX_LO-1:2];
    assign lookup_tag    = lookup_addr[31:TAG_LO];
    assign refill_index  = req_addr[TAG_LO-1:IDX_LO];
    assign req_offset    = req_addr[IDX_LO-1:2];
    assign refill_tag    = req_addr[31:TAG_LO];
    assign unused_low    = ^lookup_addr[1:0];

    icache_line_array #(
        .INDEX_BITS (INDEX_BITS),
        .BLOCK_BITS (BLOCK_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_lines (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .rd_index  (lookup_index),
        .rd_offset (lookup_offset),
        .rd_tag    (lookup_tag),
        .rd_hit    (hit),
        .rd_word   (rd_word),
        .wr_en     (word_fire & ~rst_in),
        .wr_index  (refill_index),
        .wr_offset (word_cnt),
        .wr_word   (mem_data),
        .set_en    (last_fire & ~rst_in),
        .set_tag   (refill_tag)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= IC_IDLE;
        end else if (rdy_in) begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        inst_handle = 1'b0;
        word_fire   = 1'b0;
        last_fire   = 1'b0;
        case (state)
            IC_IDLE: begin
                inst_handle = inst_req & rdy_in;
                if (inst_handle && !hit) begin
                    state_next = IC_REFILL;
                end
            end
            IC_REFILL: begin
                word_fire = mem_done & mem_req & rdy_in;
                last_fire = word_fire && (word_cnt == LAST_WORD);
                if (last_fire) begin
                    state_next = IC_IDLE;
                end
            end
            default: state_next = IC_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            inst_ready <= 1'b0;
            inst_out   <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            drop       <= 1'b0;
            word_cnt   <= '0;
            req_addr   <= '0;
        end else if (rdy_in) begin
            inst_ready <= 1'b0;
            if (inst_handle) begin
                if (hit) begin
                    inst_ready <= 1'b1;
                    inst_out   <= rd_word;
                end else begin
                    req_addr <= inst_addr;
                    mem_addr <= line_base(inst_addr, BLOCK_BITS);
                    mem_req  <= 1'b1;
                    word_cnt <= '0;
                end
            end
            if ((state == IC_REFILL) && rob_clear) begin
                drop <= 1'b1;
            end
            if (word_fire) begin
                if (last_fire) begin
                    // A flush landing on the final word still suppresses the answer.
                    mem_req    <= 1'b0;
                    inst_ready <= ~(drop | rob_clear);
                    inst_out   <= (req_offset == LAST_WORD) ? mem_data : rd_word;
                    drop       <= 1'b0;
                end else begin
                    word_cnt <= word_cnt + 1'b1;
                    mem_addr <= mem_addr + 32'd4;
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_cache.sv
// Self-checking bench for inst_cache: directed scenarios followed by random fetches,
// checked against a line-presence model and a functional memory image.
module tb_inst_cache;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_handle;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic        rob_clear;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_done;
    logic [31:0] mem_data;

    int errors = 0;
    int checks = 0;

    inst_cache dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .rdy_in      (rdy_in),
        .inst_req    (inst_req),
        .inst_addr   (inst_addr),
        .inst_handle (inst_handle),
        .inst_ready  (inst_ready),
        .inst_out    (inst_out),
        .rob_clear   (rob_clear),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_done    (mem_done),
        .mem_data    (mem_data)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Memory image: words 0x0..0xC hold 0x11,0x22,0x33,0x44; elsewhere address-derived.
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        logic [31:0] w;
        w = a & 32'hFFFF_FFFC;
        if (w < 32'h10) return ((w >> 2) + 32'd1) * 32'h11;
        return {w[15:0] ^ 16'hC3A5, w[15:0]};
    endfunction

    // Cache model: which line base address each of the 16 sets currently holds.
    bit          mv    [16];
    logic [31:0] mline [16];

    // Memory responder: acts just after each negedge, answers with random latency.
    int          done_cnt = 0;
    int          wait_cnt = 0;
    logic [31:0] mem_log [$];

    initial begin
        mem_done = 1'b0;
        mem_data = '0;
        forever begin
            @(negedge clk_in);
            #1;
            mem_done = 1'b0;
            if (mem_req && rdy_in && !rst_in) begin
                if (wait_cnt == 0) begin
                    mem_done = 1'b1;
                    mem_data = mem_fn(mem_addr);
                    mem_log.push_back(mem_addr);
                    done_cnt++;
                    wait_cnt = int'($urandom_range(0, 2));
                end else begin
                    wait_cnt--;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, want);
        end
    endtask

    // One fetch, with optional flush after N words, ready-stall after N words, or
    // a rob_clear coincident with the request.
    task automatic fetch(input logic [31:0] addr, input int flush_after,
                         input int stall_after, input bit clear_with_req);
        int          idx;
        int          start;
        int          n;
        bit          hit;
        bit          flushed;
        bit          stalled;
        logic [31:0] base;
        logic [31:0] want;
        logic [31:0] saved;
        idx  = int'((addr >> 4) & 32'hF);
        base = addr & 32'hFFFF_FFF0;
        want = mem_fn(addr);
        hit  = mv[idx] && (mline[idx] == base);
        @(negedge clk_in);
        mem_log.delete();
        start     = done_cnt;
        inst_req  = 1'b1;
        inst_addr = addr;
        rob_clear = clear_with_req;
        #1 chk("handle", {31'd0, inst_handle}, 32'd1);
        @(negedge clk_in);
        inst_req  = 1'b0;
        rob_clear = 1'b0;
        if (hit) begin
            chk("hit_ready", {31'd0, inst_ready}, 32'd1);
            chk("hit_data", inst_out, want);
            chk("hit_no_mem", {31'd0, mem_req}, 32'd0);
        end else begin
            chk("miss_req", {31'd0, mem_req}, 32'd1);
            chk("miss_addr", mem_addr, base);
            chk("miss_no_ready", {31'd0, inst_ready}, 32'd0);
            flushed = 1'b0;
            stalled = 1'b0;
            n = 0;
            while (mem_req && n < 200) begin
                if (flush_after > 0 && !flushed && (done_cnt - start) >= flush_after) begin
                    flushed   = 1'b1;
                    rob_clear = 1'b1;
                end else begin
                    rob_clear = 1'b0;
                end
                if (stall_after > 0 && !stalled && (done_cnt - start) >= stall_after) begin
                    stalled   = 1'b1;
                    saved     = mem_addr;
                    rdy_in    = 1'b0;
                    inst_req  = 1'b1;
                    inst_addr = addr ^ 32'h40;
                    for (int k = 0; k < 3; k++) begin
                        #1 chk("stall_handle", {31'd0, inst_handle}, 32'd0);
                        @(negedge clk_in);
                        chk("stall_addr", mem_addr, saved);
                        chk("stall_req", {31'd0, mem_req}, 32'd1);
                        chk("stall_ready", {31'd0, inst_ready}, 32'd0);
                    end
                    rdy_in   = 1'b1;
                    inst_req = 1'b0;
                end
                @(negedge clk_in);
                n++;
            end
            rob_clear = 1'b0;
            chk("refill_timeout", {31'd0, (n < 200)}, 32'd1);
            chk("refill_ready", {31'd0, inst_ready}, {31'd0, !flushed});
            if (!flushed) chk("refill_data", inst_out, want);
            chk("refill_words", mem_log.size(), 32'd4);
            for (int i = 0; i < mem_log.size() && i < 4; i++) begin
                chk("refill_seq", mem_log[i], base + 32'(4 * i));
            end
            mv[idx]    = 1'b1;
            mline[idx] = base;
        end
    endtask

    initial begin
        logic [31:0] b2b [3];
        int          start;
        int          n;
        int          sel;
        logic [31:0] ra;

        foreach (mv[i]) mv[i] = 1'b0;
        rst_in    = 1'b1;
        rdy_in    = 1'b1;
        inst_req  = 1'b0;
        inst_addr = '0;
        rob_clear = 1'b0;
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
        chk("rst_ready", {31'd0, inst_ready}, 32'd0);
        chk("rst_out", inst_out, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_handle", {31'd0, inst_handle}, 32'd0);

        // Cold miss returning word 2 of line 0.
        fetch(32'h0000_0008, 0, 0, 1'b0);

        // Back-to-back hits.
        b2b[0] = 32'h0;
        b2b[1] = 32'h4;
        b2b[2] = 32'hC;
        @(negedge clk_in);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                chk("b2b_ready", {31'd0, inst_ready}, 32'd1);
                chk("b2b_data", inst_out, mem_fn(b2b[i-1]));
                chk("b2b_no_mem", {31'd0, mem_req}, 32'd0);
            end
            if (i < 3) begin
                inst_req  = 1'b1;
                inst_addr = b2b[i];
                #1 chk("b2b_handle", {31'd0, inst_handle}, 32'd1);
                @(negedge clk_in);
            end else begin
                inst_req = 1'b0;
            end
        end
        @(negedge clk_in);
        chk("idle_no_ready", {31'd0, inst_ready}, 32'd0);

        // Conflict in set 0.
        fetch(32'h0000_0000, 0, 0, 1'b0);
        fetch(32'h0000_0100, 0, 0, 1'b0);
        fetch(32'h0000_0000, 0, 0, 1'b0);

        // Flush after the second word, then a hit on the installed line.
        fetch(32'h0000_0040, 2, 0, 1'b0);
        fetch(32'h0000_0044, 0, 0, 1'b0);

        // Ready stall mid-refill.
        fetch(32'h0000_0088, 0, 2, 1'b0);
        fetch(32'h0000_0080, 0, 0, 1'b0);

        // rob_clear with a request in idle does not block it.
        fetch(32'h0000_0090, 0, 0, 1'b1);

        // Reset mid-refill.
        @(negedge clk_in);
        inst_req  = 1'b1;
        inst_addr = 32'h0000_0300;
        start     = done_cnt;
        @(negedge clk_in);
        inst_req = 1'b0;
        chk("rst_refill_req", {31'd0, mem_req}, 32'd1);
        n = 0;
        while ((done_cnt - start) < 1 && n < 50) begin
            @(negedge clk_in);
            n++;
        end
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
        chk("rst_mid_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mid_ready", {31'd0, inst_ready}, 32'd0);
        chk("rst_mid_mem_addr", mem_addr, 32'd0);
        foreach (mv[i]) mv[i] = 1'b0;
        fetch(32'h0000_0008, 0, 0, 1'b0);

        // Random fetches over a few tags per set.
        for (int t = 0; t < 60; t++) begin
            ra = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 4)
               | 32'($urandom_range(0, 15));
            sel = int'($urandom_range(0, 5));
            case (sel)
                0:       fetch(ra, int'($urandom_range(1, 3)), 0, 1'b0);
                1:       fetch(ra, 0, int'($urandom_range(1, 3)), 1'b0);
                2:       fetch(ra, 0, 0, 1'b1);
                default: fetch(ra, 0, 0, 1'b0);
            endcase
        end

        repeat (2) @(negedge clk_in);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
